// File: rtl/cpu_debug_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_pkg
//  Description : Shared constants for the CPU debug controller: FSM state
//                encoding, halt-cause codes and register-window offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_debug_pkg;

  // Controller states
  localparam logic [2:0] RUN        = 3'd0;
  localparam logic [2:0] STOP       = 3'd1;
  localparam logic [2:0] STEP_ARMED = 3'd2;
  localparam logic [2:0] STEPPING   = 3'd3;
  localparam logic [2:0] RESET_WAIT = 3'd4;

  // Halt-cause codes reported in STATUS and on halt_cause
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_STEP   = 2'd2;
  localparam logic [1:0] CAUSE_BP     = 2'd3;

  // Register offsets inside the monitor window
  localparam logic [7:0] REG_STATUS    = 8'd0;
  localparam logic [7:0] REG_STEPS_LO  = 8'd1;
  localparam logic [7:0] REG_STEPS_HI  = 8'd2;
  localparam logic [7:0] REG_BP_EN     = 8'd3;
  localparam logic [7:0] REG_TRACE_SEL = 8'd4;
  localparam logic [7:0] REG_TRACE_LO  = 8'd5;
  localparam logic [7:0] REG_TRACE_HI  = 8'd6;
  localparam logic [7:0] REG_BP0       = 8'd8;

  // STATUS byte layout: {stopped, cause[1:0], 0, bp_idx[3:0]}
  function automatic logic [7:0] status_byte(input logic stopped,
                                             input logic [1:0] cause,
                                             input logic [3:0] idx);
    return {stopped, cause, 1'b0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_debug_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ctrl_if
//  Description : Byte-wide monitor register-window bus. The monitor side is
//                the master; the debug controller is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_debug_ctrl_if;
  logic [7:0] A;
  logic       write;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       win_hit;

  modport master (output A, output write, output Din, input Dout, input win_hit);
  modport slave  (input A, input write, input Din, output Dout, output win_hit);
endinterface
`default_nettype wire

// File: rtl/cpu_debug_ctrl_bp_match.sv
`default_nettype none
// ============================================================================
//  Module      : bp_match
//  Description : NUM_BP address comparators gated by an enable mask, with a
//                priority encoder returning the lowest matching index.
//                Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_match #(
  parameter int ADDR_W = 16,
  parameter int NUM_BP = 4
) (
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [NUM_BP-1:0][ADDR_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]             en_i,
  output logic                          hit_o,
  output logic [3:0]                    idx_o
);

  logic [NUM_BP-1:0] w_match;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_BP; gk++) begin : g_cmp
      assign w_match[gk] = en_i[gk] && (bp_addr_i[gk] == addr_i);
    end
  endgenerate

  // Scan from the top down so the lowest matching comparator wins
  always_comb begin
    hit_o = 1'b0;
    idx_o = 4'd0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        hit_o = 1'b1;
        idx_o = 4'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_ctrl
//  Description : Front-panel debug controller for a 6502-class CPU:
//                run/halt, counted stepping, NUM_BP address breakpoints,
//                halt-cause report and NMI pulse generation, with a
//                byte-wide monitor register window.
//  Options     : CPU_DEBUG_TRACE_EN - adds a TRACE_DEPTH-entry ring of
//                opcode-fetch addresses readable through offsets 4-6.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_debug_ctrl
  import cpu_debug_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter int         NUM_BP      = 4,
  parameter logic [7:0] WIN_BASE    = 8'hC0,
  parameter int         NMI_LEN     = 8,
  parameter int         TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_debug_ctrl_if.slave   mon,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              sync,
  input  logic              b_step,
  input  logic              b_runhalt,
  input  logic              b_reset,
  output logic              nmiN,
  output logic              stopped,
  output logic [1:0]        halt_cause
);

  localparam logic [9:0]  c_win_lo    = {2'b00, WIN_BASE};
  localparam logic [9:0]  c_win_hi    = c_win_lo + 10'(8 + 2 * NUM_BP);
  localparam logic [15:0] c_addr_mask = 16'((32'd1 << ADDR_W) - 32'd1);
  localparam int          c_nmi_w     = $clog2(NMI_LEN + 1);
  localparam logic [c_nmi_w-1:0] c_nmi_load = c_nmi_w'(NMI_LEN);

  // ---------------------------------------------------------------- state
  logic [2:0]               state_q, state_d;
  logic [1:0]               cause_q, cause_d;
  logic [3:0]               idx_q, idx_d;
  logic                     suppress_q, suppress_d;
  logic [16:0]              cnt_q, cnt_d;
  logic                     sync_q;
  logic [c_nmi_w-1:0]       nmi_cnt_q;
  logic [15:0]              steps_q;
  logic [NUM_BP-1:0]        bp_en_q;
  logic [NUM_BP-1:0][15:0]  bp_q;
  logic [7:0]               dout_q;

  // ---------------------------------------------------------------- wires
  logic                          w_rise;
  logic                          w_win_hit;
  logic [7:0]                    w_off;
  logic                          w_wr;
  logic                          w_go;
  logic                          w_clr;
  logic                          w_halt;
  logic                          w_bp_hit;
  logic                          w_match_hit;
  logic [3:0]                    w_match_idx;
  logic [15:0]                   w_steps_eff;
  logic [7:0]                    w_rdata;
  logic [NUM_BP-1:0][ADDR_W-1:0] w_bp_cmp;

  assign w_rise      = sync & ~sync_q;
  assign w_win_hit   = ({2'b00, mon.A} >= c_win_lo) && ({2'b00, mon.A} < c_win_hi);
  assign w_off       = mon.A - WIN_BASE;
  assign w_wr        = mon.write & w_win_hit;
  assign w_go        = w_wr && (w_off == REG_STATUS) && mon.Din[0];
  assign w_clr       = w_wr && (w_off == REG_STATUS) && mon.Din[1];
  assign w_steps_eff = (steps_q == 16'd0) ? 16'd1 : steps_q;
  assign w_bp_hit    = w_rise & ~suppress_q & w_match_hit;

  assign mon.win_hit = w_win_hit;
  assign mon.Dout    = dout_q;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_BP; gk++) begin : g_bp_cmp
      assign w_bp_cmp[gk] = bp_q[gk][ADDR_W-1:0];
    end
  endgenerate

  bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .addr_i    (cpu_addr),
    .bp_addr_i (w_bp_cmp),
    .en_i      (bp_en_q),
    .hit_o     (w_match_hit),
    .idx_o     (w_match_idx)
  );

`ifdef CPU_DEBUG_TRACE_EN
  localparam int c_tr_w = $clog2(TRACE_DEPTH);

  logic [TRACE_DEPTH-1:0][ADDR_W-1:0] trace_q;
  logic [c_tr_w-1:0]                  tr_wptr_q;
  logic [7:0]                         tr_sel_q;
  logic [c_tr_w-1:0]                  w_tr_idx;
  logic [15:0]                        w_tr_data;

  // Newest entry sits just behind the write pointer; selection counts back
  assign w_tr_idx  = tr_wptr_q - c_tr_w'(1) - tr_sel_q[c_tr_w-1:0];
  assign w_tr_data = 16'(trace_q[w_tr_idx]);

  // Record fetch addresses while the CPU runs user code (not in the monitor)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_q   <= '0;
      tr_wptr_q <= '0;
      tr_sel_q  <= 8'd0;
    end else begin
      if (w_rise && (state_q != STOP)) begin
        trace_q[tr_wptr_q] <= cpu_addr;
        tr_wptr_q          <= tr_wptr_q + c_tr_w'(1);
      end
      if (w_wr && (w_off == REG_TRACE_SEL)) begin
        tr_sel_q <= mon.Din;
      end
    end
  end
`endif

  // Opcode-fetch edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync;
    end
  end

  // FSM state register plus the step counter and suppress flag it owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cause_q    <= CAUSE_NONE;
      idx_q      <= 4'd0;
      suppress_q <= 1'b0;
      cnt_q      <= 17'd0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      idx_q      <= idx_d;
      suppress_q <= suppress_d;
      cnt_q      <= cnt_d;
    end
  end

  // FSM next-state logic; a halt also requests an NMI pulse
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    idx_d      = idx_q;
    suppress_d = w_rise ? 1'b0 : suppress_q;
    cnt_d      = cnt_q;
    w_halt     = 1'b0;
    case (state_q)
      RUN: begin
        if (w_bp_hit) begin
          state_d = STOP;
          w_halt  = 1'b1;
          cause_d = CAUSE_BP;
          idx_d   = w_match_idx;
        end else if (b_step || b_runhalt) begin
          state_d = STOP;
          w_halt  = 1'b1;
          cause_d = CAUSE_BUTTON;
        end
      end
      STOP: begin
        if (b_reset) begin
          state_d = RESET_WAIT;
        end else if (b_runhalt) begin
          state_d    = RUN;
          suppress_d = 1'b1;
        end else if (b_step) begin
          state_d = STEP_ARMED;
        end
      end
      STEP_ARMED: begin
        if (b_reset) begin
          state_d = RUN;
        end else if (w_go) begin
          state_d    = STEPPING;
          cnt_d      = 17'd0;
          suppress_d = 1'b1;
        end
      end
      STEPPING: begin
        if (b_reset) begin
          state_d = RUN;
        end else if (w_bp_hit) begin
          state_d = STOP;
          w_halt  = 1'b1;
          cause_d = CAUSE_BP;
          idx_d   = w_match_idx;
        end else if (w_rise && (cnt_q == {1'b0, w_steps_eff})) begin
          // First rise is the RTI return fetch, so STEPS+1 rises end the step
          state_d = STOP;
          w_halt  = 1'b1;
          cause_d = CAUSE_STEP;
        end else if (w_rise && (cnt_q != 17'h1FFFF)) begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      RESET_WAIT: begin
        if (b_reset) begin
          state_d = RUN;
        end else if (w_rise) begin
          state_d = STOP;
          w_halt  = 1'b1;
          cause_d = CAUSE_BUTTON;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // A fresh halt cause takes precedence over a monitor clear
    if (!w_halt && w_clr) begin
      cause_d = CAUSE_NONE;
      idx_d   = 4'd0;
    end
  end

  // FSM outputs
  always_comb begin
    stopped    = (state_q == STOP);
    halt_cause = cause_q;
    nmiN       = (nmi_cnt_q == '0);
  end

  // NMI pulse: load on a request only when idle, so a pulse is never extended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_cnt_q <= '0;
    end else if (w_halt && (nmi_cnt_q == '0)) begin
      nmi_cnt_q <= c_nmi_load;
    end else if (nmi_cnt_q != '0) begin
      nmi_cnt_q <= nmi_cnt_q - c_nmi_w'(1);
    end
  end

  // Monitor-writable configuration: step count, enables and breakpoints
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q <= 16'd1;
      bp_en_q <= '0;
      bp_q    <= '0;
    end else if (w_wr) begin
      if (w_off == REG_STEPS_LO) steps_q[7:0]  <= mon.Din;
      if (w_off == REG_STEPS_HI) steps_q[15:8] <= mon.Din;
      if (w_off == REG_BP_EN)    bp_en_q       <= mon.Din[NUM_BP-1:0];
      for (int k = 0; k < NUM_BP; k++) begin
        if (w_off == 8'(REG_BP0 + 8'(2 * k)))
          bp_q[k][7:0]  <= mon.Din & c_addr_mask[7:0];
        if (w_off == 8'(REG_BP0 + 8'(2 * k + 1)))
          bp_q[k][15:8] <= mon.Din & c_addr_mask[15:8];
      end
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    w_rdata = 8'h00;
    if (w_win_hit) begin
      case (w_off)
        REG_STATUS:    w_rdata = status_byte(state_q == STOP, cause_q, idx_q);
        REG_STEPS_LO:  w_rdata = steps_q[7:0];
        REG_STEPS_HI:  w_rdata = steps_q[15:8];
        REG_BP_EN:     w_rdata = 8'(bp_en_q);
`ifdef CPU_DEBUG_TRACE_EN
        REG_TRACE_SEL: w_rdata = tr_sel_q;
        REG_TRACE_LO:  w_rdata = w_tr_data[7:0];
        REG_TRACE_HI:  w_rdata = w_tr_data[15:8];
`endif
        default:       w_rdata = 8'h00;
      endcase
      for (int k = 0; k < NUM_BP; k++) begin
        if (w_off == 8'(REG_BP0 + 8'(2 * k)))     w_rdata = bp_q[k][7:0];
        if (w_off == 8'(REG_BP0 + 8'(2 * k + 1))) w_rdata = bp_q[k][15:8];
      end
    end
  end

  // Registered read data, one cycle behind the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_debug_ctrl
//  Description : Self-checking bench for cpu_debug_ctrl. A behavioural model
//                tracks the controller mode, the NMI pulse and the register
//                file; outputs are compared every cycle, and directed
//                sequences pin the model with literal expectations.
//  Options     : CPU_DEBUG_TRACE_EN - also models and checks the trace ring.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_debug_ctrl;

  localparam int         ADDR_W      = 16;
  localparam int         NUM_BP      = 4;
  localparam logic [7:0] WIN_BASE    = 8'hC0;
  localparam int         NMI_LEN     = 8;
  localparam int         TRACE_DEPTH = 8;
  localparam int         WIN_SIZE    = 8 + 2 * NUM_BP;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic              sync, b_step, b_runhalt, b_reset;
  logic              nmiN, stopped;
  logic [1:0]        halt_cause;

  cpu_debug_ctrl_if mon_if ();

  always #5 clk = ~clk;

  cpu_debug_ctrl #(
    .ADDR_W      (ADDR_W),
    .NUM_BP      (NUM_BP),
    .WIN_BASE    (WIN_BASE),
    .NMI_LEN     (NMI_LEN),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon        (mon_if),
    .cpu_addr   (cpu_addr),
    .sync       (sync),
    .b_step     (b_step),
    .b_runhalt  (b_runhalt),
    .b_reset    (b_reset),
    .nmiN       (nmiN),
    .stopped    (stopped),
    .halt_cause (halt_cause)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef enum {M_RUN, M_STOP, M_ARMED, M_STEP, M_RWAIT} mode_t;

  mode_t       m_mode;
  logic        m_sync_prev;
  logic        m_supp;
  int          m_rises;
  logic [1:0]  m_cause;
  logic [3:0]  m_idx;
  int          m_nmi_left;
  logic [15:0] m_steps;
  logic [7:0]  m_bpen;
  logic [15:0] m_bp [NUM_BP];
  logic [7:0]  m_dout;
  logic [7:0]  m_trsel;
  logic [15:0] m_tr [$];

  function automatic bit in_win(input logic [7:0] a);
    return (int'(a) >= int'(WIN_BASE)) && (int'(a) < int'(WIN_BASE) + WIN_SIZE);
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_sync_prev = 1'b0; m_supp = 1'b0; m_rises = 0;
    m_cause = 2'd0; m_idx = 4'd0; m_nmi_left = 0; m_steps = 16'd1;
    m_bpen = 8'd0; m_dout = 8'd0; m_trsel = 8'd0; m_tr.delete();
    for (int k = 0; k < NUM_BP; k++) m_bp[k] = 16'd0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] off);
    logic [15:0] t;
    int sel;
    t = 16'd0;
    if (off == 8'd0) return {m_mode == M_STOP, m_cause, 1'b0, m_idx};
    if (off == 8'd1) return m_steps[7:0];
    if (off == 8'd2) return m_steps[15:8];
    if (off == 8'd3) return m_bpen;
`ifdef CPU_DEBUG_TRACE_EN
    sel = int'(m_trsel) % TRACE_DEPTH;
    if (sel < m_tr.size()) t = m_tr[sel];
    if (off == 8'd4) return m_trsel;
    if (off == 8'd5) return t[7:0];
    if (off == 8'd6) return t[15:8];
`else
    sel = 0;
`endif
    if (off >= 8'd8) begin
      t = m_bp[(int'(off) - 8) / 2];
      return off[0] ? t[15:8] : t[7:0];
    end
    return 8'd0;
  endfunction

  task automatic model_step();
    logic rise, halt, setsup, wr, go, clr;
    logic [1:0] hc;
    logic [7:0] off;
    int hitk, steff;
    mode_t old;
    rise = sync && !m_sync_prev;
    m_sync_prev = sync;
    wr  = mon_if.write && in_win(mon_if.A);
    off = mon_if.A - WIN_BASE;
    m_dout = in_win(mon_if.A) ? model_read(off) : 8'd0;
    hitk = -1;
    if (rise && !m_supp)
      for (int k = NUM_BP - 1; k >= 0; k--)
        if (m_bpen[k] && m_bp[k] == cpu_addr) hitk = k;
    go  = wr && off == 8'd0 && mon_if.Din[0];
    clr = wr && off == 8'd0 && mon_if.Din[1];
    steff = (m_steps == 16'd0) ? 1 : int'(m_steps);
    halt = 1'b0; setsup = 1'b0; hc = 2'd0; old = m_mode;
    case (m_mode)
      M_RUN:
        if (hitk >= 0) begin halt = 1; hc = 2'd3; m_idx = 4'(hitk); m_mode = M_STOP; end
        else if (b_step || b_runhalt) begin halt = 1; hc = 2'd1; m_mode = M_STOP; end
      M_STOP:
        if (b_reset) m_mode = M_RWAIT;
        else if (b_runhalt) begin m_mode = M_RUN; setsup = 1; end
        else if (b_step) m_mode = M_ARMED;
      M_ARMED:
        if (b_reset) m_mode = M_RUN;
        else if (go) begin m_mode = M_STEP; m_rises = 0; setsup = 1; end
      M_STEP:
        if (b_reset) m_mode = M_RUN;
        else if (hitk >= 0) begin halt = 1; hc = 2'd3; m_idx = 4'(hitk); m_mode = M_STOP; end
        else if (rise && m_rises == steff) begin halt = 1; hc = 2'd2; m_mode = M_STOP; end
        else if (rise && m_rises < 131071) m_rises++;
      M_RWAIT:
        if (b_reset) m_mode = M_RUN;
        else if (rise) begin halt = 1; hc = 2'd1; m_mode = M_STOP; end
      default: m_mode = M_RUN;
    endcase
`ifdef CPU_DEBUG_TRACE_EN
    if (rise && old != M_STOP) begin
      m_tr.push_front(cpu_addr);
      if (m_tr.size() > TRACE_DEPTH) void'(m_tr.pop_back());
    end
    if (wr && off == 8'd4) m_trsel = mon_if.Din;
`endif
    if (setsup) m_supp = 1'b1;
    else if (rise) m_supp = 1'b0;
    if (halt && m_nmi_left == 0) m_nmi_left = NMI_LEN;
    else if (m_nmi_left > 0) m_nmi_left--;
    if (halt) m_cause = hc;
    else if (clr) begin m_cause = 2'd0; m_idx = 4'd0; end
    if (wr) begin
      if (off == 8'd1) m_steps[7:0]  = mon_if.Din;
      if (off == 8'd2) m_steps[15:8] = mon_if.Din;
      if (off == 8'd3) m_bpen = mon_if.Din & 8'((1 << NUM_BP) - 1);
      if (off >= 8'd8 && int'(off) < WIN_SIZE) begin
        if (off[0]) m_bp[(int'(off) - 8) / 2][15:8] = mon_if.Din;
        else        m_bp[(int'(off) - 8) / 2][7:0]  = mon_if.Din;
      end
    end
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("nmiN",       nmiN,       m_nmi_left == 0);
    chk("stopped",    stopped,    m_mode == M_STOP);
    chk("halt_cause", halt_cause, m_cause);
    chk("win_hit",    mon_if.win_hit, in_win(mon_if.A));
    chk("Dout",       mon_if.Dout, m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    mon_if.A = WIN_BASE + 8'(off); mon_if.Din = d; mon_if.write = 1'b1;
    tick();
    mon_if.write = 1'b0; mon_if.A = 8'h00;
  endtask

  task automatic rd(input int off, output logic [7:0] d);
    mon_if.A = WIN_BASE + 8'(off);
    tick();
    d = mon_if.Dout;
    mon_if.A = 8'h00;
  endtask

  task automatic rise(input logic [15:0] a);
    cpu_addr = a; sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
  endtask

  task automatic pulse_runhalt(); b_runhalt = 1'b1; tick(); b_runhalt = 1'b0; endtask
  task automatic pulse_step();    b_step    = 1'b1; tick(); b_step    = 1'b0; endtask
  task automatic pulse_reset();   b_reset   = 1'b1; tick(); b_reset   = 1'b0; endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [7:0] v;
    int lows, off;
    logic [7:0] pool [4];
    logic [15:0] apool [6];
    pool[0] = 8'h00; pool[1] = 8'h12; pool[2] = 8'h34; pool[3] = 8'h80;
    apool[0] = 16'h1234; apool[1] = 16'h8000; apool[2] = 16'h0000;
    apool[3] = 16'h3412; apool[4] = 16'h1280; apool[5] = 16'h0100;

    rst_n = 1'b0; cpu_addr = '0; sync = 1'b0;
    b_step = 1'b0; b_runhalt = 1'b0; b_reset = 1'b0;
    mon_if.A = 8'h00; mon_if.write = 1'b0; mon_if.Din = 8'h00;
    model_reset();
    idle(2);
    chk("reset_nmiN", nmiN, 1'b1);
    chk("reset_stopped", stopped, 1'b0);
    chk("reset_cause", halt_cause, 2'd0);
    chk("reset_Dout", mon_if.Dout, 8'h00);
    rst_n = 1'b1;
    idle(2);
    rd(1, v); chk("reset_steps_lo", v, 8'h01);

    // Button halt from RUN
    pulse_runhalt();
    lows = (nmiN == 1'b0) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin tick(); if (!nmiN) lows++; end
    chk("nmi_len", lows, NMI_LEN);
    chk("halt_stopped", stopped, 1'b1);
    rd(0, v); chk("status_button", v, 8'hA0);

    // Counted step of 3 instructions
    pulse_step();
    wr(1, 8'd3); wr(2, 8'd0); wr(0, 8'h01);
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      rise(16'h0200 + 16'(i));
      if (!nmiN) lows++;
    end
    chk("step_early_nmi", lows, 0);
    rise(16'h0203);
    chk("step_nmi", nmiN, 1'b0);
    chk("step_cause", halt_cause, 2'd2);
    idle(10);
    wr(0, 8'h02);

    // Single breakpoint, then resume at it with suppression
    wr(10, 8'h34); wr(11, 8'h12); wr(3, 8'h02);
    pulse_runhalt();
    rise(16'h0100);
    rise(16'h1234);
    chk("bp1_nmi", nmiN, 1'b0);
    idle(10);
    rd(0, v); chk("status_bp1", v, 8'hE1);
    pulse_runhalt();
    rise(16'h1234);
    chk("bp_suppressed", nmiN, 1'b1);
    chk("bp_suppressed_run", stopped, 1'b0);
    rise(16'h1234);
    chk("bp_retrigger", nmiN, 1'b0);
    idle(10);

    // Two breakpoints on the same address: lowest index wins
    wr(8, 8'h00); wr(9, 8'h80); wr(12, 8'h00); wr(13, 8'h80); wr(3, 8'h05);
    wr(0, 8'h02);
    pulse_runhalt();
    rise(16'h0100);
    rise(16'h8000);
    idle(10);
    rd(0, v); chk("status_bp0", v, 8'hE0);
    wr(0, 8'h02);
    pulse_runhalt();
    rise(16'h0100);
    cpu_addr = 16'h8000; sync = 1'b1; b_runhalt = 1'b1;
    tick();
    b_runhalt = 1'b0; sync = 1'b0;
    tick();
    chk("bp_beats_button", halt_cause, 2'd3);
    idle(10);

    // Reset button in STOP waits for the first fetch
    wr(0, 8'h02);
    pulse_reset();
    chk("rwait_no_nmi", nmiN, 1'b1);
    chk("rwait_running", stopped, 1'b0);
    rise(16'h0300);
    chk("rwait_nmi", nmiN, 1'b0);
    chk("rwait_cause", halt_cause, 2'd1);
    idle(10);

    // Trace ring
    wr(3, 8'h00);
    pulse_runhalt();
    for (int i = 1; i <= 10; i++) rise(16'(i));
    pulse_runhalt();
    idle(10);
    wr(4, 8'd0);
    rd(5, v);
`ifdef CPU_DEBUG_TRACE_EN
    chk("trace_sel0", v, 8'd10);
    wr(4, 8'd7);
    rd(5, v); chk("trace_sel7", v, 8'd3);
    rd(6, v); chk("trace_sel7_hi", v, 8'd0);
`else
    chk("trace_absent", v, 8'd0);
`endif

    // Asynchronous reset in the middle of an NMI pulse
    pulse_runhalt();
    idle(2);
    pulse_step();
    idle(2);
    chk("pre_rst_nmi", nmiN, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_nmiN", nmiN, 1'b1);
    chk("rst_mid_stopped", stopped, 1'b0);
    chk("rst_mid_cause", halt_cause, 2'd0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      sync      = 1'($urandom_range(0, 1));
      cpu_addr  = apool[$urandom_range(0, 5)];
      b_step    = ($urandom_range(0, 29) == 0);
      b_runhalt = ($urandom_range(0, 29) == 0);
      b_reset   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) != 0) begin
        off = $urandom_range(0, WIN_SIZE - 1);
        mon_if.A = WIN_BASE + 8'(off);
      end else begin
        mon_if.A = 8'($urandom);
        off = int'(8'(mon_if.A - WIN_BASE));
      end
      mon_if.write = ($urandom_range(0, 3) == 0);
      if (off == 1)      mon_if.Din = 8'($urandom_range(0, 5));
      else if (off == 2) mon_if.Din = 8'h00;
      else if (off >= 8) mon_if.Din = pool[$urandom_range(0, 3)];
      else               mon_if.Din = 8'($urandom);
      tick();
    end
    sync = 1'b0; b_step = 1'b0; b_runhalt = 1'b0; b_reset = 1'b0; mon_if.write = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
